// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//
// Contents:
//   shift_mode_e - 2-bit operation select (SLL, SRL, SRA, ROR)
//   ModeW        - width of the mode field
//
// Optional feature macro used by the files importing this package: BARREL_CARRY_EN.
package barrel_pkg;

    localparam int unsigned ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        ModeSll = 2'b00,
        ModeSrl = 2'b01,
        ModeSra = 2'b10,
        ModeRor = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/barrel_stage.sv
// One shift-by-2^STAGE step of the barrel shifter with its elastic pipeline register.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_data    - upstream operation (valid, operand so far)
//   in_amt/in_mode      - full shift amount and mode travelling with the operand
//   in_carry/out_carry  - last bit shifted out so far (only with BARREL_CARRY_EN)
//   out_ready           - downstream can take this stage's contents
//   out_valid/out_data  - registered stage contents
//   out_amt/out_mode    - amount and mode forwarded to the next stage
//
// The stage loads whenever it is empty or downstream is ready; otherwise every field holds.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STAGE = 0,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  shift_mode_e      in_mode,
`ifdef BARREL_CARRY_EN
    input  logic             in_carry,
    output logic             out_carry,
`endif
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output shift_mode_e      out_mode
);

    localparam int unsigned Dist = 2 ** STAGE;

    logic             valid_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   amt_q;
    shift_mode_e      mode_q;
    logic             load;

    assign load = ~valid_q | out_ready;

`ifdef BARREL_CARRY_EN
    logic carry_q, carry_d;
`endif

    always_comb begin
        data_d = in_data;
`ifdef BARREL_CARRY_EN
        carry_d = in_carry;
`endif
        if (in_amt[STAGE]) begin
            unique case (in_mode)
                ModeSll: data_d = {in_data[WIDTH-Dist-1:0], {Dist{1'b0}}};
                ModeSrl: data_d = {{Dist{1'b0}}, in_data[WIDTH-1:Dist]};
                ModeSra: data_d = {{Dist{in_data[WIDTH-1]}}, in_data[WIDTH-1:Dist]};
                ModeRor: data_d = {in_data[Dist-1:0], in_data[WIDTH-1:Dist]};
                default: data_d = in_data;
            endcase
`ifdef BARREL_CARRY_EN
            // Carry is the last bit leaving the word; for ROR it equals the new MSB.
            if (in_mode == ModeSll) begin
                carry_d = in_data[WIDTH-Dist];
            end else begin
                carry_d = in_data[Dist-1];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= ModeSll;
`ifdef BARREL_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else if (load) begin
            valid_q <= in_valid;
            data_q  <= data_d;
            amt_q   <= in_amt;
            mode_q  <= in_mode;
`ifdef BARREL_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_amt   = amt_q;
    assign out_mode  = mode_q;
`ifdef BARREL_CARRY_EN
    assign out_carry = carry_q;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   in_valid/in_ready            - operation handshake (accepted when both high)
//   in_data/in_amt/in_mode       - operand, shift amount, mode (00 SLL 01 SRL 10 SRA 11 ROR)
//   out_valid/out_ready          - result handshake (consumed when both high)
//   out_data                     - shifted result
//   out_carry                    - last bit shifted out (only with BARREL_CARRY_EN)
//
// SHW = $clog2(WIDTH) stages, latency SHW, one operation per cycle, capacity SHW.
// Optional feature macro: BARREL_CARRY_EN.
module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
`ifdef BARREL_CARRY_EN
    output logic             out_carry,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [SHW-1:0]   vld;
    logic [SHW-1:0]   dn_rdy;
    logic [WIDTH-1:0] dat  [SHW];
    logic [SHW-1:0]   amt  [SHW];
    shift_mode_e      mode [SHW];
`ifdef BARREL_CARRY_EN
    logic [SHW-1:0]   car;
`endif

    // Ready of stage k's downstream, unrolled from the tail so no combinational
    // path runs between stage instances.
    always_comb begin
        dn_rdy = '0;
        dn_rdy[SHW-1] = out_ready;
        for (int k = int'(SHW) - 2; k >= 0; k--) begin
            dn_rdy[k] = ~vld[k+1] | dn_rdy[k+1];
        end
    end

    assign in_ready = ~vld[0] | dn_rdy[0];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic             s_valid;
        logic [WIDTH-1:0] s_data;
        logic [SHW-1:0]   s_amt;
        shift_mode_e      s_mode;
`ifdef BARREL_CARRY_EN
        logic             s_carry;
`endif

        if (k == 0) begin : g_head
            assign s_valid = in_valid;
            assign s_data  = in_data;
            assign s_amt   = in_amt;
            assign s_mode  = shift_mode_e'(in_mode);
`ifdef BARREL_CARRY_EN
            assign s_carry = 1'b0;
`endif
        end else begin : g_link
            assign s_valid = vld[k-1];
            assign s_data  = dat[k-1];
            assign s_amt   = amt[k-1];
            assign s_mode  = mode[k-1];
`ifdef BARREL_CARRY_EN
            assign s_carry = car[k-1];
`endif
        end

        barrel_stage #(
            .WIDTH(WIDTH),
            .STAGE(k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (s_valid),
            .in_data  (s_data),
            .in_amt   (s_amt),
            .in_mode  (s_mode),
`ifdef BARREL_CARRY_EN
            .in_carry (s_carry),
            .out_carry(car[k]),
`endif
            .out_ready(dn_rdy[k]),
            .out_valid(vld[k]),
            .out_data (dat[k]),
            .out_amt  (amt[k]),
            .out_mode (mode[k])
        );
    end

    // The tail stage's amount and mode have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt[SHW-1], mode[SHW-1]};

    assign out_valid = vld[SHW-1];
    assign out_data  = dat[SHW-1];
`ifdef BARREL_CARRY_EN
    assign out_carry = car[SHW-1];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH=8), scoreboard based.
// Carry checks are compiled in when BARREL_CARRY_EN is defined.
module tb_barrel_shifter_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amt = 3'd0;
    logic [1:0] in_mode = 2'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
`ifdef BARREL_CARRY_EN
    logic       out_carry;
`endif

    always #5 clk = ~clk;

    barrel_shifter_pipe #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_mode  (in_mode),
`ifdef BARREL_CARRY_EN
        .out_carry(out_carry),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    typedef struct {
        logic [7:0] data;
        logic       carry;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pops = 0;
    int         accepts = 0;
    bit         lat_check = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic       last_carry = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-amount shift, independent of the staged structure.
    function automatic void model(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                                  output logic [7:0] r, output logic c);
        int          ai;
        logic [15:0] dd;
        ai = int'(a);
        case (m)
            2'b00: begin r = d << a; c = (ai == 0) ? 1'b0 : d[8-ai]; end
            2'b01: begin r = d >> a; c = (ai == 0) ? 1'b0 : d[ai-1]; end
            2'b10: begin r = 8'($signed(d) >>> a); c = (ai == 0) ? 1'b0 : d[ai-1]; end
            default: begin
                dd = {d, d} >> a;
                r  = dd[7:0];
                c  = (ai == 0) ? 1'b0 : r[7];
            end
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop and compare on emit, check holding while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() > 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_out: observed=%0h expected=no output", out_data);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", {24'b0, out_data}, {24'b0, e.data});
`ifdef BARREL_CARRY_EN
                    chk("out_carry", {31'b0, out_carry}, {31'b0, e.carry});
                    last_carry = out_carry;
`endif
                    if (lat_check) chk("latency", cyc - e.acc, 3);
                    last_data = out_data;
                    pops++;
                end
            end else if (out_valid && !out_ready && sb.size() > 0) begin
                chk("hold_data", {24'b0, out_data}, {24'b0, sb[0].data});
`ifdef BARREL_CARRY_EN
                chk("hold_carry", {31'b0, out_carry}, {31'b0, sb[0].carry});
`endif
            end
            if (in_valid && in_ready) begin
                model(in_data, in_amt, in_mode, e.data, e.carry);
                e.acc = cyc;
                sb.push_back(e);
                accepts++;
            end
        end
    end

    task automatic run_one(input string tag, input logic [7:0] d, input logic [2:0] a,
                           input logic [1:0] m, input logic [7:0] gd, input logic gc);
        in_data   = d;
        in_amt    = a;
        in_mode   = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat_check = 1'b1;
        @(negedge clk);
        chk({tag, "_accept"}, {31'b0, in_ready}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_drain"}, sb.size(), 0);
        chk({tag, "_data"}, {24'b0, last_data}, {24'b0, gd});
`ifdef BARREL_CARRY_EN
        chk({tag, "_carry"}, {31'b0, last_carry}, {31'b0, gc});
`else
        if (gc === 1'bx) $display("note: %s", tag);
`endif
        lat_check = 1'b0;
    endtask

    logic [7:0] t4d[8] = '{8'hB5, 8'h96, 8'h81, 8'hFF, 8'h3C, 8'hA5, 8'h7E, 8'h01};
    logic [2:0] t4a[8] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd4, 3'd5, 3'd6};
    logic [1:0] t4m[8] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        int i;
        int stall;
        int pops0;
        int target;
        bit saw;
        bit saw_full;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {24'b0, out_data}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single operations with golden values
        run_one("sll_b5_3", 8'hB5, 3'd3, 2'b00, 8'hA8, 1'b1);
        run_one("sra_96_2", 8'h96, 3'd2, 2'b10, 8'hE5, 1'b1);
        run_one("srl_96_2", 8'h96, 3'd2, 2'b01, 8'h25, 1'b1);
        run_one("ror_81_1", 8'h81, 3'd1, 2'b11, 8'hC0, 1'b1);
        run_one("srl_ff_0", 8'hFF, 3'd0, 2'b01, 8'hFF, 1'b0);
        run_one("sll_01_7", 8'h01, 3'd7, 2'b00, 8'h80, 1'b0);

        // Backpressure: 8 back-to-back ops, out_ready low for 4 cycles at first out_valid
        i = 0;
        stall = 0;
        saw = 1'b0;
        saw_full = 1'b0;
        pops0 = pops;
        for (int c = 0; c < 80 && (i < 8 || sb.size() > 0); c++) begin
            in_valid = (i < 8);
            if (i < 8) begin
                in_data = t4d[i];
                in_amt  = t4a[i];
                in_mode = t4m[i];
            end
            if (!saw && out_valid) begin
                saw   = 1'b1;
                stall = 4;
            end
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            @(negedge clk);
            if (!in_ready) saw_full = 1'b1;
            if (in_valid && in_ready) i++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_in_ready_fell", {31'b0, saw_full}, 1);
        chk("bp_all_accepted", i, 8);
        chk("bp_drain", sb.size(), 0);
        chk("bp_pop_count", pops - pops0, 8);

        // Reset mid-stream with 3 operations in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = t4d[k+3];
            in_amt   = t4a[k+3];
            in_mode  = t4m[k+3];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_out_data", {24'b0, out_data}, 0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
        out_ready = 1'b1;
        pops0 = pops;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_ghosts", pops - pops0, 0);
        run_one("after_rst", 8'h1F, 3'd4, 2'b00, 8'hF0, 1'b1);

        // Random traffic against the model
        target = accepts + 1000;
        for (int c = 0; c < 20000 && accepts < target; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("rand_accepts", accepts, target);
        chk("rand_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
